mac_accum_seq: RTL and testbench

Sequenced accumulator directly downstream of the 16x16 MAC product stage. Takes the 35-bit zero-extended unsigned product stream, sums a programmable number of terms into a 40-bit saturating accumulator, and presents the final dot-product sum to the consumer over a valid/ready handshake. It turns the single-product register into a real multiply-accumulate for vector lengths up to 255.

---
 rtl/mac_accum_seq.sv | 120 ++++++++++++
 tb/tb_mac_accum_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : mac_accum_seq
// Purpose  : Sums len unsigned MAC products into a saturating accumulator and
//            hands the dot-product result to a valid/ready consumer.
// Revision : 1.0
// ============================================================================
module mac_accum_seq #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [34:0]      prod,
  input  logic             prod_vld,
  output logic             mac_en,
  output logic             busy,
  output logic [ACC_W-1:0] res,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             ovf
);

  localparam int PROD_W = 35;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic [ACC_W-1:0]   acc_q;
  logic               res_vld_q;
  logic               ovf_q;

  logic [ACC_W:0]     sum_w;
  logic [ACC_W-1:0]   acc_d;
  logic               sat_d;
  logic               last_d;

  // One ACC_W+1 bit adder: the carry out is the saturation flag.
  assign sum_w  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign sat_d  = sum_w[ACC_W];
  assign acc_d  = sat_d ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  assign last_d = (cnt_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (abort) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q <= len;
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            if (len == '0) begin
              state_q   <= DONE;
              res_vld_q <= 1'b1;
            end else begin
              state_q   <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (prod_vld) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + LEN_W'(1);
            if (sat_d) begin
              ovf_q <= 1'b1;
            end
            if (last_d) begin
              state_q   <= DONE;
              res_vld_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (res_rdy) begin
            state_q   <= IDLE;
            res_vld_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          res_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign mac_en  = (state_q == ACCUM);
  assign busy    = (state_q != IDLE);
  assign res     = acc_q;
  assign res_vld = res_vld_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accum_seq
// Purpose  : Directed self-checking bench for mac_accum_seq.
// Revision : 1.0
// ============================================================================
module tb_mac_accum_seq;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic [34:0] prod;
  logic        prod_vld;
  logic        mac_en;
  logic        busy;
  logic [39:0] res;
  logic        res_vld;
  logic        res_rdy;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;
  int mac_cnt;

  mac_accum_seq #(.ACC_W(40), .LEN_W(8)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .prod     (prod),
    .prod_vld (prod_vld),
    .mac_en   (mac_en),
    .busy     (busy),
    .res      (res),
    .res_vld  (res_vld),
    .res_rdy  (res_rdy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [34:0] v, input int gap);
    repeat (gap) begin
      prod_vld = 1'b0;
      tick();
    end
    prod     = v;
    prod_vld = 1'b1;
    tick();
    prod_vld = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    prod = '0; prod_vld = 1'b0; res_rdy = 1'b0;

    #3;
    chk_eq("rst_res",     res,     0);
    chk_eq("rst_res_vld", res_vld, 0);
    chk_eq("rst_busy",    busy,    0);
    chk_eq("rst_ovf",     ovf,     0);
    chk_eq("rst_mac_en",  mac_en,  0);
    #5 clr_n = 1'b1;
    tick();

    // Basic back-to-back sum
    do_start(8'd4);
    mac_cnt = 0;
    chk_eq("basic_busy", busy, 1);
    if (mac_en) mac_cnt++;
    for (int i = 1; i <= 4; i++) begin
      prod = 35'(i); prod_vld = 1'b1;
      tick();
      if (mac_en) mac_cnt++;
      chk_eq("basic_vld_timing", res_vld, (i == 4) ? 1 : 0);
    end
    prod_vld = 1'b0;
    chk_eq("basic_res",    res,     10);
    chk_eq("basic_ovf",    ovf,     0);
    chk_eq("basic_mac_en", mac_cnt, 4);
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    chk_eq("basic_drop_vld",  res_vld, 0);
    chk_eq("basic_drop_busy", busy,    0);

    // Gapped input, stray prod_vld in DONE and IDLE
    do_start(8'd3);
    feed(35'd100, 1);
    feed(35'd200, 1);
    feed(35'd300, 1);
    chk_eq("gap_res", res, 600);
    feed(35'd999, 0);
    chk_eq("gap_done_ignore", res,     600);
    chk_eq("gap_done_vld",    res_vld, 1);
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    feed(35'd999, 0);
    chk_eq("gap_idle_ignore", res,  600);
    chk_eq("gap_idle_busy",   busy, 0);

    // Saturation
    do_start(8'd40);
    for (int i = 1; i <= 40; i++) begin
      feed(35'h7_FFFF_FFFF, 0);
      if (i == 32) chk_eq("sat_ovf_32", ovf, 0);
      if (i == 33) chk_eq("sat_ovf_33", ovf, 1);
    end
    chk_eq("sat_res",  res,     40'hFF_FFFF_FFFF);
    chk_eq("sat_vld",  res_vld, 1);
    chk_eq("sat_ovf",  ovf,     1);
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    chk_eq("sat_idle_ovf", ovf, 1);
    do_start(8'd2);
    chk_eq("sat_clr_ovf", ovf, 0);
    feed(35'd5, 0);
    feed(35'd7, 0);
    chk_eq("sum2_res", res, 12);

    // Back-pressure with start held
    len = 8'd0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq("bp_res", res,     12);
      chk_eq("bp_vld", res_vld, 1);
    end
    start = 1'b0;
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    chk_eq("bp_release_busy", busy,    0);
    chk_eq("bp_release_vld",  res_vld, 0);
    do_start(8'd0);
    chk_eq("len0_vld", res_vld, 1);
    chk_eq("len0_res", res,     0);
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;

    // Abort on the final term
    do_start(8'd3);
    feed(35'd10, 0);
    feed(35'd20, 0);
    prod = 35'd30; prod_vld = 1'b1; abort = 1'b1;
    tick();
    prod_vld = 1'b0; abort = 1'b0;
    chk_eq("abort_busy", busy,    0);
    chk_eq("abort_vld",  res_vld, 0);
    chk_eq("abort_res",  res,     0);
    len = 8'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_eq("abort_start_busy",   busy,   0);
    chk_eq("abort_start_mac_en", mac_en, 0);

    // Asynchronous reset mid-accumulation
    do_start(8'd5);
    feed(35'd1, 0);
    feed(35'd2, 0);
    feed(35'd3, 0);
    chk_eq("pre_rst_res", res, 6);
    #2 clr_n = 1'b0;
    #1;
    chk_eq("arst_res",  res,     0);
    chk_eq("arst_vld",  res_vld, 0);
    chk_eq("arst_busy", busy,    0);
    chk_eq("arst_ovf",  ovf,     0);
    #1 clr_n = 1'b1;
    tick();
    do_start(8'd2);
    feed(35'd5, 0);
    feed(35'd7, 0);
    chk_eq("post_rst_res", res,     12);
    chk_eq("post_rst_vld", res_vld, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
